// File: rtl/sram_arbiter.sv
// sram_arbiter: two-master (inst/data) to one SRAM-like slave arbiter with in-order response routing.
// Define SRAM_ARB_RR_EN for round-robin tie-break instead of fixed data-over-inst priority.
module sram_arbiter #(
    parameter int MAX_OUTSTANDING = 2,
    parameter int ADDR_W          = 32
) (
    input  logic              clk,
    input  logic              resetn,
    input  logic              inst_req,
    input  logic              inst_wr,
    input  logic [1:0]        inst_size,
    input  logic [3:0]        inst_wstrb,
    input  logic [ADDR_W-1:0] inst_addr,
    input  logic [31:0]       inst_wdata,
    output logic              inst_addr_ok,
    output logic              inst_data_ok,
    output logic [31:0]       inst_rdata,
    input  logic              data_req,
    input  logic              data_wr,
    input  logic [1:0]        data_size,
    input  logic [3:0]        data_wstrb,
    input  logic [ADDR_W-1:0] data_addr,
    input  logic [31:0]       data_wdata,
    output logic              data_addr_ok,
    output logic              data_data_ok,
    output logic [31:0]       data_rdata,
    output logic              s_req,
    output logic              s_wr,
    output logic [1:0]        s_size,
    output logic [3:0]        s_wstrb,
    output logic [ADDR_W-1:0] s_addr,
    output logic [31:0]       s_wdata,
    input  logic              s_addr_ok,
    input  logic              s_data_ok,
    input  logic [31:0]       s_rdata,
    output logic              arb_err
);
    localparam int PW = MAX_OUTSTANDING > 1 ? $clog2(MAX_OUTSTANDING) : 1;
    localparam int CW = $clog2(MAX_OUTSTANDING) + 1;

    typedef enum logic [1:0] {IDLE, GNT_INST, GNT_DATA} state_t;

    state_t                     state_q, state_d;
    logic [MAX_OUTSTANDING-1:0] ids_q;
    logic [PW-1:0]              wr_q, rd_q;
    logic [CW-1:0]              cnt_q;
    logic                       err_q;
    logic                       pop, full, push, pick_data, pick_inst, gi, gd, g_req, head;

    assign head = ids_q[rd_q];
    assign pop  = s_data_ok && cnt_q != '0;
    // a same-cycle pop frees the slot, so a push is still accepted when full
    assign full = cnt_q == CW'(MAX_OUTSTANDING) && !pop;

`ifdef SRAM_ARB_RR_EN
    logic last_q;
    assign pick_data = data_req && (!inst_req || !last_q);
`else
    assign pick_data = data_req;
`endif
    assign pick_inst = inst_req && !pick_data;

    assign gi    = resetn && (state_q == GNT_INST || (state_q == IDLE && !full && pick_inst));
    assign gd    = resetn && (state_q == GNT_DATA || (state_q == IDLE && !full && pick_data));
    assign g_req = (gi && inst_req) || (gd && data_req);
    assign s_req = g_req && !full;
    assign push  = s_req && s_addr_ok;

    assign inst_addr_ok = push && gi;
    assign data_addr_ok = push && gd;
    assign inst_data_ok = pop && !head;
    assign data_data_ok = pop && head;
    assign inst_rdata   = s_rdata;
    assign data_rdata   = s_rdata;
    assign arb_err      = err_q;

    assign s_wr    = (gi && inst_wr) || (gd && data_wr);
    assign s_size  = ({2{gi}} & inst_size) | ({2{gd}} & data_size);
    assign s_wstrb = ({4{gi}} & inst_wstrb) | ({4{gd}} & data_wstrb);
    assign s_addr  = ({ADDR_W{gi}} & inst_addr) | ({ADDR_W{gd}} & data_addr);
    assign s_wdata = ({32{gi}} & inst_wdata) | ({32{gd}} & data_wdata);

    // hold the grant until the granted master's request is accepted or withdrawn
    assign state_d = (g_req && !push) ? (gd ? GNT_DATA : GNT_INST) : IDLE;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q <= IDLE;
            ids_q   <= '0;
            wr_q    <= '0;
            rd_q    <= '0;
            cnt_q   <= '0;
            err_q   <= 1'b0;
`ifdef SRAM_ARB_RR_EN
            last_q  <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_q + CW'(push) - CW'(pop);
            if (push) begin
                ids_q[wr_q] <= gd;
                wr_q        <= wr_q == PW'(MAX_OUTSTANDING - 1) ? '0 : wr_q + 1'b1;
`ifdef SRAM_ARB_RR_EN
                last_q      <= gd;
`endif
            end
            if (pop)
                rd_q <= rd_q == PW'(MAX_OUTSTANDING - 1) ? '0 : rd_q + 1'b1;
            if (s_data_ok && cnt_q == '0)
                err_q <= 1'b1;
        end
    end
endmodule

// File: tb/tb_sram_arbiter.sv
// tb_sram_arbiter: directed vectors, scoreboard of expected handshakes checked by a monitor.
module tb_sram_arbiter;
    typedef struct packed {
        logic [3:0]  oks;
        logic [31:0] addr;
        logic [31:0] rdata;
    } exp_t;

    logic        clk = 1'b0;
    logic        resetn;
    logic        inst_req, inst_wr, data_req, data_wr;
    logic [1:0]  inst_size, data_size, s_size;
    logic [3:0]  inst_wstrb, data_wstrb, s_wstrb;
    logic [31:0] inst_addr, inst_wdata, data_addr, data_wdata;
    logic        inst_addr_ok, inst_data_ok, data_addr_ok, data_data_ok;
    logic [31:0] inst_rdata, data_rdata;
    logic        s_req, s_wr, s_addr_ok, s_data_ok, arb_err;
    logic [31:0] s_addr, s_wdata, s_rdata;

    exp_t sb[$];
    int   n_vec = 0;
    int   n_err = 0;

    always #5 clk = ~clk;

    sram_arbiter dut (
        .clk(clk), .resetn(resetn),
        .inst_req(inst_req), .inst_wr(inst_wr), .inst_size(inst_size), .inst_wstrb(inst_wstrb),
        .inst_addr(inst_addr), .inst_wdata(inst_wdata), .inst_addr_ok(inst_addr_ok),
        .inst_data_ok(inst_data_ok), .inst_rdata(inst_rdata),
        .data_req(data_req), .data_wr(data_wr), .data_size(data_size), .data_wstrb(data_wstrb),
        .data_addr(data_addr), .data_wdata(data_wdata), .data_addr_ok(data_addr_ok),
        .data_data_ok(data_data_ok), .data_rdata(data_rdata),
        .s_req(s_req), .s_wr(s_wr), .s_size(s_size), .s_wstrb(s_wstrb), .s_addr(s_addr),
        .s_wdata(s_wdata), .s_addr_ok(s_addr_ok), .s_data_ok(s_data_ok), .s_rdata(s_rdata),
        .arb_err(arb_err)
    );

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h", nm, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_in();
        inst_req = 0; inst_wr = 0; inst_size = 2'd2; inst_wstrb = 4'hf; inst_addr = 0; inst_wdata = 0;
        data_req = 0; data_wr = 0; data_size = 2'd2; data_wstrb = 4'hf; data_addr = 0; data_wdata = 0;
        s_addr_ok = 0; s_data_ok = 0; s_rdata = 0;
    endtask

    task automatic expect_ok(input logic [3:0] oks, input logic [31:0] a, input logic [31:0] r);
        exp_t e;
        e.oks = oks; e.addr = a; e.rdata = r;
        sb.push_back(e);
    endtask

    function automatic logic [3:0] oks_now();
        return {inst_addr_ok, data_addr_ok, inst_data_ok, data_data_ok};
    endfunction

    task automatic monitor();
        exp_t o, e;
        forever begin
            @(negedge clk);
            o.oks = oks_now();
            if (resetn && o.oks != 0) begin
                o.addr  = (o.oks[3] || o.oks[2]) ? s_addr : 32'h0;
                o.rdata = o.oks[1] ? inst_rdata : (o.oks[0] ? data_rdata : 32'h0);
                n_vec++;
                if (sb.size() == 0) begin
                    n_err++;
                    $display("FAIL unexpected response: got oks=%b addr=%h rdata=%h, nothing expected",
                             o.oks, o.addr, o.rdata);
                end else begin
                    e = sb.pop_front();
                    if (o !== e) begin
                        n_err++;
                        $display("FAIL response: got oks=%b addr=%h rdata=%h, expected oks=%b addr=%h rdata=%h",
                                 o.oks, o.addr, o.rdata, e.oks, e.addr, e.rdata);
                    end
                end
            end
        end
    endtask

    initial begin
        fork monitor(); join_none
        resetn = 0;
        idle_in();
        inst_req = 1; inst_addr = 32'h11110000;
        #2;
        chk("reset s_req", {31'h0, s_req}, 0);
        chk("reset oks", {28'h0, oks_now()}, 0);
        chk("reset s_addr", s_addr, 0);
        chk("reset arb_err", {31'h0, arb_err}, 0);
        step();
        resetn = 1;
        idle_in();

        // single instruction read, response two cycles after acceptance
        step();
        inst_req = 1; inst_addr = 32'h1c000000; s_addr_ok = 1;
        expect_ok(4'b1000, 32'h1c000000, 0);
        #2 chk("t1 s_addr", s_addr, 32'h1c000000);
        step(); idle_in();
        step(); s_data_ok = 1; s_rdata = 32'h02800000;
        expect_ok(4'b0010, 0, 32'h02800000);
        step(); idle_in();

        // contention: data wins, then inst; responses routed in order
        step();
        inst_req = 1; inst_addr = 32'h1c000010; data_req = 1; data_addr = 32'h80001000; s_addr_ok = 1;
        expect_ok(4'b0100, 32'h80001000, 0);
        step(); data_req = 0;
        expect_ok(4'b1000, 32'h1c000010, 0);
        step(); idle_in(); s_data_ok = 1; s_rdata = 32'haaaa0001;
        expect_ok(4'b0001, 0, 32'haaaa0001);
        step(); s_rdata = 32'hbbbb0002;
        expect_ok(4'b0010, 0, 32'hbbbb0002);
        step(); idle_in();

        // slave stalls: grant stays on data with stable request fields
        step();
        data_req = 1; data_wr = 1; data_addr = 32'hbfaf8000; data_wdata = 32'h12345678;
        #2 chk("t3 s_req stall", {31'h0, s_req}, 1);
        step(); inst_req = 1; inst_addr = 32'h1c000100;
        #2 chk("t3 s_addr hold1", s_addr, 32'hbfaf8000);
        step();
        #2 chk("t3 s_wdata hold", s_wdata, 32'h12345678);
        step(); s_addr_ok = 1;
        expect_ok(4'b0100, 32'hbfaf8000, 0);
        #2 chk("t3 s_addr hs", s_addr, 32'hbfaf8000);
        step(); data_req = 0; data_wr = 0;
        expect_ok(4'b1000, 32'h1c000100, 0);
        step(); idle_in(); s_data_ok = 1; s_rdata = 32'h00000003;
        expect_ok(4'b0001, 0, 32'h00000003);
        step(); s_rdata = 32'h00000004;
        expect_ok(4'b0010, 0, 32'h00000004);
        step(); idle_in();

        // full queue blocks, simultaneous pop+push keeps it full
        step(); inst_req = 1; inst_addr = 32'h00000100; s_addr_ok = 1;
        expect_ok(4'b1000, 32'h00000100, 0);
        step(); inst_req = 0; data_req = 1; data_addr = 32'h00000200;
        expect_ok(4'b0100, 32'h00000200, 0);
        step(); data_req = 0; inst_req = 1; inst_addr = 32'h00000300;
        #2 chk("t4 full s_req", {31'h0, s_req}, 0);
        step(); s_data_ok = 1; s_rdata = 32'h0000cafe;
        expect_ok(4'b1010, 32'h00000300, 32'h0000cafe);
        step(); s_data_ok = 0; inst_addr = 32'h00000400;
        #2 chk("t4 still full", {31'h0, s_req}, 0);
        step(); idle_in(); s_data_ok = 1; s_rdata = 32'h0000beef;
        expect_ok(4'b0001, 0, 32'h0000beef);
        step(); s_rdata = 32'h0000f00d;
        expect_ok(4'b0010, 0, 32'h0000f00d);
        step(); idle_in();

        // orphan response sets sticky error, cleared by reset
        step(); s_data_ok = 1; s_rdata = 32'hdeadbeef;
        #2 chk("t5 no data_ok", {30'h0, inst_data_ok, data_data_ok}, 0);
        step(); idle_in();
        #2 chk("t5 arb_err set", {31'h0, arb_err}, 1);
        step();
        chk("t5 arb_err sticky", {31'h0, arb_err}, 1);
        #2 resetn = 0;
        #1 chk("t5 arb_err cleared", {31'h0, arb_err}, 0);
        step(); resetn = 1;

        // asynchronous reset with a request in flight
        step(); inst_req = 1; inst_addr = 32'h1c000200; s_addr_ok = 1;
        expect_ok(4'b1000, 32'h1c000200, 0);
        step(); data_req = 1; data_addr = 32'h80002000; resetn = 0;
        #1;
        chk("t6 s_req in reset", {31'h0, s_req}, 0);
        chk("t6 oks in reset", {28'h0, oks_now()}, 0);
        chk("t6 s_addr in reset", s_addr, 0);
        step(); resetn = 1; idle_in(); s_data_ok = 1; s_rdata = 32'h77777777;
        #2 chk("t6 late data_ok", {30'h0, inst_data_ok, data_data_ok}, 0);
        step(); idle_in();
        #2 chk("t6 arb_err", {31'h0, arb_err}, 1);

        for (int i = 0; i < 20 && sb.size() != 0; i++) step();
        chk("scoreboard drained", sb.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
